// File: rtl/trig_sched_pkg.sv
// Shared types and constants for the trigger pulse scheduler.
// State encoding, default sizes and a constant-safe clog2.
package trig_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int NREQ_DEF  = 4;
  localparam int LEN_W_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/trig_pulse_sched_if.sv
// Requester/config inputs and pulse/status outputs of the scheduler.
// The master drives requests and config; the slave is the scheduler.
interface trig_pulse_sched_if
  import trig_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  localparam int ID_W = clog2(NREQ);

  logic [NREQ-1:0]  REQ;
  logic [NREQ-1:0]  ENABLE;
  logic [LEN_W-1:0] WIDTH;
  logic [LEN_W-1:0] HOLDOFF;
  logic             OUT;
  logic [ID_W-1:0]  OUT_ID;
  logic             BUSY;
  logic [NREQ-1:0]  PENDING;
  logic [NREQ-1:0]  OVERRUN;

  modport master (
    output REQ, ENABLE, WIDTH, HOLDOFF,
    input  OUT, OUT_ID, BUSY, PENDING, OVERRUN
  );

  modport slave (
    input  REQ, ENABLE, WIDTH, HOLDOFF,
    output OUT, OUT_ID, BUSY, PENDING, OVERRUN
  );

endinterface

// File: rtl/trig_req_edge.sv
// One requester: rising-edge detect with pending latch and overrun flag.
// A new edge on the granting cycle re-arms pending instead of overrunning.
module trig_req_edge
  import trig_sched_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic req,
  input  logic en,
  input  logic grant,
  output logic pending,
  output logic overrun
);

  logic prev_q;
  logic rise;

  assign rise = req & ~prev_q & en;

  // prev resets high so a level held through reset is not a request
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q  <= 1'b1;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      prev_q  <= req;
      pending <= rise | (pending & ~grant);
      overrun <= rise & pending & ~grant;
    end
  end

endmodule

// File: rtl/trig_pulse_sched.sv
// Round-robin trigger scheduler: one stretched pulse at a time,
// followed by an optional holdoff, sharing one down-counter.
module trig_pulse_sched
  import trig_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input logic CLK,
  input logic RST,
  trig_pulse_sched_if.slave bus
);

  localparam int ID_W = clog2(NREQ);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] hold_q, hold_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             out_q, busy_q;

  logic [NREQ-1:0]  pend, ovr, gnt;
  logic [ID_W-1:0]  win, win_hi, win_lo;
  logic             found, hit_hi;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    trig_req_edge u_edge (
      .CLK     (CLK),
      .RST     (RST),
      .req     (bus.REQ[i]),
      .en      (bus.ENABLE[i]),
      .grant   (gnt[i]),
      .pending (pend[i]),
      .overrun (ovr[i])
    );
  end

  // lowest pending above last grant, else lowest at/below it
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    hit_hi = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (pend[j] && (j > int'(last_q))) begin
        hit_hi = 1'b1;
        win_hi = ID_W'(j);
      end
      if (pend[j] && (j <= int'(last_q))) begin
        win_lo = ID_W'(j);
      end
    end
    win   = hit_hi ? win_hi : win_lo;
    found = |pend;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    last_d  = last_q;
    id_d    = id_q;
    gnt     = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt[win] = 1'b1;
          last_d   = win;
          id_d     = win;
          hold_d   = bus.HOLDOFF;
          cnt_d    = (bus.WIDTH == '0) ? LEN_W'(1) : bus.WIDTH;
          state_d  = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q <= LEN_W'(1)) begin
          if (hold_q != '0) begin
            state_d = HOLD;
            cnt_d   = hold_q;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q <= LEN_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      last_q  <= ID_W'(NREQ - 1);
      id_q    <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      id_q    <= id_d;
      out_q   <= (state_d == PULSE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.OUT     = out_q;
  assign bus.OUT_ID  = id_q;
  assign bus.BUSY    = busy_q;
  assign bus.PENDING = pend;
  assign bus.OVERRUN = ovr;

endmodule

// File: tb/tb_trig_pulse_sched.sv
// Bench for trig_pulse_sched: timeline reference model plus
// directed scenarios and randomized traffic.
module tb_trig_pulse_sched;

  localparam int N  = 4;
  localparam int LW = 8;

  logic CLK = 1'b0;
  logic RST;

  trig_pulse_sched_if #(.NREQ(N), .LEN_W(LW)) bus ();

  trig_pulse_sched #(.NREQ(N), .LEN_W(LW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  // model: pending set, last grant, and the time window of the last pulse
  logic [N-1:0] m_prev = '1;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_ovr  = '0;
  int m_last  = N - 1;
  int m_id    = 0;
  int g_t     = -1000;
  int g_w     = 0;
  int g_h     = 0;
  int next_ok = 0;
  logic ex_out  = 1'b0;
  logic ex_busy = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] e;
    logic [N-1:0] g;
    int w;
    cyc++;
    if (RST) begin
      m_prev  = '1;
      m_pend  = '0;
      m_ovr   = '0;
      m_last  = N - 1;
      m_id    = 0;
      g_t     = -1000;
      g_w     = 0;
      g_h     = 0;
      next_ok = cyc + 1;
    end else begin
      e      = bus.REQ & ~m_prev & bus.ENABLE;
      m_prev = bus.REQ;
      g      = '0;
      if (cyc >= next_ok && m_pend != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && m_pend[(m_last + k) % N]) w = (m_last + k) % N;
        end
        g[w]    = 1'b1;
        m_last  = w;
        m_id    = w;
        g_t     = cyc;
        g_w     = (bus.WIDTH == '0) ? 1 : int'(bus.WIDTH);
        g_h     = int'(bus.HOLDOFF);
        next_ok = cyc + g_w + g_h + 1;
      end
      m_ovr  = e & m_pend & ~g;
      m_pend = (m_pend & ~g) | e;
    end
    ex_out  = (cyc >= g_t) && (cyc < g_t + g_w);
    ex_busy = (cyc >= g_t) && (cyc < g_t + g_w + g_h);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (cyc >= 1) begin
      cmp("m_out",  32'(bus.OUT),     32'(ex_out));
      cmp("m_busy", 32'(bus.BUSY),    32'(ex_busy));
      cmp("m_id",   32'(bus.OUT_ID),  32'(m_id));
      cmp("m_pend", 32'(bus.PENDING), 32'(m_pend));
      cmp("m_ovr",  32'(bus.OVERRUN), 32'(m_ovr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    bus.REQ = '0;
    tick(1);
    RST = 1'b0;
    tick(1);
  endtask

  initial begin
    RST         = 1'b1;
    bus.REQ     = '0;
    bus.ENABLE  = '1;
    bus.WIDTH   = 8'd1;
    bus.HOLDOFF = '0;
    tick(2);
    cmp("rst_out",  32'(bus.OUT),     32'd0);
    cmp("rst_busy", 32'(bus.BUSY),    32'd0);
    cmp("rst_id",   32'(bus.OUT_ID),  32'd0);
    cmp("rst_pend", 32'(bus.PENDING), 32'd0);
    RST = 1'b0;
    tick(1);

    // single request, width 3, holdoff 2
    bus.WIDTH   = 8'd3;
    bus.HOLDOFF = 8'd2;
    bus.REQ     = 4'b0010;
    tick(1);
    cmp("s1_pend", 32'(bus.PENDING), 32'h2);
    cmp("s1_out0", 32'(bus.OUT), 32'd0);
    tick(1);
    cmp("s1_out1", 32'(bus.OUT), 32'd1);
    cmp("s1_id",   32'(bus.OUT_ID), 32'd1);
    tick(2);
    cmp("s1_out3", 32'(bus.OUT), 32'd1);
    tick(1);
    cmp("s1_outlo", 32'(bus.OUT), 32'd0);
    cmp("s1_hold",  32'(bus.BUSY), 32'd1);
    tick(1);
    cmp("s1_hold2", 32'(bus.BUSY), 32'd1);
    tick(1);
    cmp("s1_idle",  32'(bus.BUSY), 32'd0);
    bus.REQ = '0;
    tick(2);

    // round-robin from reset
    do_reset();
    bus.WIDTH   = 8'd1;
    bus.HOLDOFF = 8'd0;
    bus.REQ     = 4'b1111;
    tick(1);
    tick(1);
    cmp("rr_id0",  32'(bus.OUT_ID), 32'd0);
    cmp("rr_out0", 32'(bus.OUT), 32'd1);
    tick(1);
    cmp("rr_gap",  32'(bus.OUT), 32'd0);
    tick(1);
    cmp("rr_id1",  32'(bus.OUT_ID), 32'd1);
    cmp("rr_out1", 32'(bus.OUT), 32'd1);
    tick(2);
    cmp("rr_id2",  32'(bus.OUT_ID), 32'd2);
    tick(2);
    cmp("rr_id3",  32'(bus.OUT_ID), 32'd3);
    cmp("rr_out3", 32'(bus.OUT), 32'd1);
    bus.REQ = '0;
    tick(3);

    // overrun on requester 2 during requester 0's pulse
    do_reset();
    bus.WIDTH = 8'd6;
    bus.REQ   = 4'b0001;
    tick(2);
    bus.REQ = 4'b0101;
    tick(1);
    bus.REQ = 4'b0001;
    tick(1);
    bus.REQ = 4'b0101;
    tick(1);
    cmp("ov_flag", 32'(bus.OVERRUN), 32'h4);
    tick(1);
    cmp("ov_clr",  32'(bus.OVERRUN), 32'h0);
    tick(3);
    cmp("ov_id2",  32'(bus.OUT_ID), 32'd2);
    cmp("ov_out",  32'(bus.OUT), 32'd1);
    cmp("ov_pend", 32'(bus.PENDING), 32'h0);
    tick(8);
    cmp("ov_done", 32'(bus.BUSY), 32'd0);
    bus.REQ = '0;
    tick(2);

    // masked edge, then width 0 on requester 3
    bus.ENABLE = 4'b1110;
    bus.REQ    = 4'b0001;
    tick(1);
    cmp("mk_pend", 32'(bus.PENDING), 32'h0);
    tick(3);
    cmp("mk_out",  32'(bus.OUT), 32'd0);
    bus.REQ     = '0;
    bus.ENABLE  = '1;
    bus.WIDTH   = 8'd0;
    bus.HOLDOFF = 8'd0;
    tick(1);
    bus.REQ = 4'b1000;
    tick(2);
    cmp("w0_out", 32'(bus.OUT), 32'd1);
    cmp("w0_id",  32'(bus.OUT_ID), 32'd3);
    tick(1);
    cmp("w0_end", 32'(bus.OUT), 32'd0);
    bus.REQ = '0;
    tick(2);

    // reset in the middle of a long pulse
    bus.WIDTH = 8'd200;
    bus.REQ   = 4'b0010;
    tick(2);
    bus.REQ = 4'b0110;
    tick(49);
    cmp("rm_out",  32'(bus.OUT), 32'd1);
    cmp("rm_pend", 32'(bus.PENDING), 32'h4);
    RST = 1'b1;
    tick(1);
    cmp("rm_out0", 32'(bus.OUT), 32'd0);
    cmp("rm_pnd0", 32'(bus.PENDING), 32'h0);
    RST = 1'b0;
    tick(10);
    cmp("rm_quiet", 32'(bus.OUT), 32'd0);
    cmp("rm_idle",  32'(bus.BUSY), 32'd0);
    bus.REQ = '0;
    tick(2);

    // edge on the granting cycle re-arms requester 0
    do_reset();
    bus.WIDTH = 8'd2;
    bus.REQ   = 4'b0010;
    tick(1);
    bus.REQ = 4'b0011;
    tick(1);
    bus.REQ = 4'b0010;
    tick(2);
    bus.REQ = 4'b0011;
    tick(1);
    cmp("eg_out",  32'(bus.OUT), 32'd1);
    cmp("eg_id",   32'(bus.OUT_ID), 32'd0);
    cmp("eg_pend", 32'(bus.PENDING), 32'h1);
    cmp("eg_ovr",  32'(bus.OVERRUN), 32'h0);
    tick(3);
    cmp("eg_out2", 32'(bus.OUT), 32'd1);
    cmp("eg_id2",  32'(bus.OUT_ID), 32'd0);
    cmp("eg_pnd2", 32'(bus.PENDING), 32'h0);
    bus.REQ = '0;
    tick(4);

    // randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0)
        bus.REQ = bus.REQ ^ N'($urandom_range(0, 15));
      if ($urandom_range(0, 20) == 0)
        bus.ENABLE = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 10) == 0) begin
        bus.WIDTH = ($urandom_range(0, 99) == 0) ? 8'd255
                  : 8'($urandom_range(0, 4));
        bus.HOLDOFF = 8'($urandom_range(0, 3));
      end
      RST = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    RST = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trig_pulse_sched.md
TRIG_PULSE_SCHED -- requirements
Module: trig_pulse_sched

Interface
REQ-001 Parameter NREQ, default 4, number of trigger requesters (2..8).
REQ-002 Parameter LEN_W, default 8, width of the pulse-width and holdoff fields.
REQ-003 CLK  input  1  sole clock; all logic on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 REQ  input  NREQ  per-requester trigger level; a rising edge is one request.
REQ-006 ENABLE  input  NREQ  per-requester mask; a masked edge is ignored, with no overrun.
REQ-007 WIDTH  input  LEN_W  output pulse length in cycles; 0 is treated as 1.
REQ-008 HOLDOFF  input  LEN_W  dead cycles after each pulse; 0 means no holdoff.
REQ-009 OUT  output  1  registered stretched trigger pulse.
REQ-010 OUT_ID  output  clog2(NREQ)  index of the requester that owns the current/last pulse.
REQ-011 BUSY  output  1  high in PULSE or HOLD.
REQ-012 PENDING  output  NREQ  latched, not-yet-served requests.
REQ-013 OVERRUN  output  NREQ  one-cycle flag: an edge arrived while that requester's pending bit was already set.

Function
REQ-014 Edge detect: an edge is recorded for requester i at the clock edge where REQ[i] is sampled 1, the previous sample was 0, and ENABLE[i] is 1.
REQ-015 Pending set: a recorded edge sets PENDING[i] at the same clock edge.
REQ-016 Pending clear: a grant clears PENDING[i]; if an edge for i is recorded on the granting edge, the set wins and OVERRUN[i] stays 0.
REQ-017 OVERRUN: OVERRUN[i] pulses for one cycle if an edge for i is recorded while PENDING[i]=1 and i is not granted on that edge; the request is merged, not queued.
REQ-018 States: IDLE, PULSE, HOLD.
REQ-019 IDLE: if any PENDING bit is set, grant that clock edge, then go to PULSE with OUT=1.
  - Grant winner: round-robin, searching upward from (last granted index + 1) mod NREQ.
  - At grant: OUT_ID takes the winner, WIDTH is captured (0->1), HOLDOFF is captured.
REQ-020 PULSE: OUT=1 for exactly the captured width in cycles.
  - Then HOLD if captured HOLDOFF is nonzero, else IDLE.
  - OUT goes low on the same edge as this transition.
REQ-021 HOLD: OUT=0 for exactly the captured HOLDOFF cycles, then IDLE.
REQ-022 Timing consequences:
  - Minimum request-to-pulse latency: REQ sampled high at edge k -> OUT high after edge k+1.
  - Back-to-back: with HOLDOFF=0 and more requests pending, the next pulse starts after exactly one IDLE cycle with OUT=0.
REQ-023 WIDTH/HOLDOFF changes mid-pulse have no effect until the next grant.
REQ-024 ENABLE deassertion does not clear an existing PENDING bit.
REQ-025 Counter: a single LEN_W-bit down-counter serves PULSE and HOLD; no wrap-around is permitted; a width of 2^LEN_W-1 must work.
REQ-026 OUT_ID holds its value outside PULSE until the next grant.

Reset
REQ-027 Reset values:
  - State=IDLE, OUT=0, BUSY=0, OUT_ID=0, PENDING=0, OVERRUN=0, counter=0.
  - Round-robin pointer set so requester 0 has first priority.
REQ-028 Previous-sample registers of REQ reset to 1, so a REQ held high through reset generates no request.
REQ-029 Reset asserted mid-PULSE or mid-HOLD forces OUT=0 on the next edge and discards all pending requests.

Structure
REQ-030 Shared package trig_sched_pkg holds:
  - state enumeration (IDLE, PULSE, HOLD);
  - default NREQ and LEN_W constants;
  - clog2 helper.
REQ-031 One sub-module, trig_req_edge: per-requester rising-edge detector plus pending/overrun latch, instantiated NREQ times.
REQ-032 Arbiter and counter live in the top module; all outputs are registered.

Verification
REQ-033 Single request: WIDTH=3, HOLDOFF=2, REQ[1] rises at edge 10 -> OUT high after edges 11..13, OUT_ID=1, BUSY low after edge 16.
REQ-034 Round-robin: all four REQ rise on the same edge, WIDTH=1, HOLDOFF=0 -> pulses served in order 0,1,2,3 with one OUT=0 cycle between pulses.
REQ-035 Overrun: REQ[2] pulses twice during another requester's pulse -> one OVERRUN[2] pulse and one served pulse for requester 2.
REQ-036 Masking and WIDTH=0:
  - ENABLE=4'b1110, REQ[0] edge -> no pulse.
  - WIDTH=0 request on requester 3 -> 1-cycle pulse.
REQ-037 Reset mid-pulse: WIDTH=200, RST asserted at pulse cycle 50 with REQ[1] held high -> OUT=0 next edge, PENDING=0, no pulse after RST release.
REQ-038 Edge on grant: REQ[0] edge recorded on the same edge that grants requester 0 -> PENDING[0]=1, OVERRUN[0]=0, second pulse for requester 0 follows.
